// File: rtl/hex_display.sv
// Multi-digit hexadecimal 7-segment driver with word load, nibble shift-in,
// leading-zero blanking and a free-running blink that blanks every digit.
module hex_display #(
   parameter int DIGITS       = 4,
   parameter int BLINK_CYCLES = 25_000_000,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_shift,
   input  logic [4*DIGITS-1:0]   in_data,
   input  logic                  clear,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic [7*DIGITS-1:0]   out,
   output logic                  full
);

   localparam int CNTW = $clog2(DIGITS + 1);
   localparam int BCW  = $clog2(BLINK_CYCLES + 1);

   localparam logic [CNTW-1:0]     COUNT_FULL = CNTW'(DIGITS);
   localparam logic [BCW-1:0]      BLINK_MAX  = BCW'(BLINK_CYCLES - 1);
   // XOR mask that converts active-high segments to the pad polarity;
   // it is also the pattern of a digit with every segment off.
   localparam logic [6:0]          SEG_POL    = {7{ACTIVE_LOW}};
   localparam logic [7*DIGITS-1:0] ALL_BLANK  = {DIGITS{SEG_POL}};

   logic [4*DIGITS-1:0] v_q, v_d;
   logic [CNTW-1:0]     count_q, count_d;
   logic                full_q, full_d;
   logic [BCW-1:0]      blink_cnt_q, blink_cnt_d;
   logic                phase_q, phase_d;
   logic [7*DIGITS-1:0] out_q, out_d;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Held value and nibble count: clear beats any load or shift.
   always_comb begin
      v_d     = v_q;
      count_d = count_q;
      if (clear) begin
         v_d     = '0;
         count_d = '0;
      end else if (in_valid) begin
         if (!in_shift) begin
            v_d     = in_data;
            count_d = COUNT_FULL;
         end else begin
            v_d      = v_q << 4;
            v_d[3:0] = in_data[3:0];
            if (count_q != COUNT_FULL) begin
               count_d = count_q + 1'b1;
            end
         end
      end
      full_d = (count_d == COUNT_FULL);
   end

   // Blink timer parks at zero while disabled so a re-enable starts visible.
   always_comb begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
      if (blink_en) begin
         if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
         end
      end
   end

   always_comb begin : render
      logic       seen_nz;
      logic [3:0] nib;
      seen_nz = 1'b0;
      out_d   = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib     = v_q[4*i +: 4];
         seen_nz = seen_nz | (nib != 4'h0);
         if ((blink_en && phase_q) || (blank_lz && !seen_nz && (i != 0))) begin
            out_d[7*i +: 7] = SEG_POL;
         end else begin
            out_d[7*i +: 7] = seg7(nib) ^ SEG_POL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q         <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         out_q       <= ALL_BLANK;
      end else begin
         v_q         <= v_d;
         count_q     <= count_d;
         full_q      <= full_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         out_q       <= out_d;
      end
   end

   assign out  = out_q;
   assign full = full_q;

endmodule

// File: tb/tb_hex_display.sv
// Directed bench for hex_display (4 digits, active-low, 4-cycle blink) with a
// per-cycle reference model and hand-computed literal checkpoints.
module tb_hex_display;
  localparam int BLINK = 4;
  localparam logic [27:0] BLANK4 = 28'hFFFFFFF;
  localparam logic [27:0] ZERO4  = {4{7'h40}};
  localparam logic [6:0] SEG_HI [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                         7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                         7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_shift;
  logic [15:0] in_data;
  logic        clear;
  logic        blank_lz;
  logic        blink_en;
  logic [27:0] out;
  logic        full;

  int total = 0;
  int bad   = 0;

  hex_display #(.DIGITS(4), .BLINK_CYCLES(BLINK), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_shift(in_shift),
    .in_data(in_data), .clear(clear), .blank_lz(blank_lz), .blink_en(blink_en),
    .out(out), .full(full)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected display image: digit i shows nibble i unless the whole display is
  // in its blink-off half or the value is smaller than 16**i with blanking on.
  function automatic logic [27:0] render(input logic [15:0] v, input logic lz,
                                         input logic blank_all);
    logic [27:0] r;
    logic [3:0]  nib;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      nib = v[4*i +: 4];
      if (blank_all || (lz && i > 0 && int'(v) < (1 << (4*i))))
        r[7*i +: 7] = 7'h7F;
      else
        r[7*i +: 7] = ~SEG_HI[nib];
    end
    return r;
  endfunction

  // Reference model: value, nibble count, and the number of consecutive
  // enabled blink cycles (phase = that count / BLINK, mod 2).
  logic [15:0] m_v;
  int          m_cnt;
  int          m_run;
  logic        model_ok = 1'b0;
  logic [27:0] exp_out;
  logic        exp_full;

  always @(posedge clk) begin
    if (rst) begin
      m_v      = '0;
      m_cnt    = 0;
      m_run    = 0;
      exp_out  = BLANK4;
      model_ok = 1'b1;
    end else if (model_ok) begin
      exp_out = render(m_v, blank_lz, blink_en && (((m_run / BLINK) % 2) == 1));
      if (clear) begin
        m_v   = '0;
        m_cnt = 0;
      end else if (in_valid && !in_shift) begin
        m_v   = in_data;
        m_cnt = 4;
      end else if (in_valid) begin
        m_v   = {m_v[11:0], in_data[3:0]};
        m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      end
      m_run = blink_en ? m_run + 1 : 0;
    end
    exp_full = (m_cnt == 4);
    #1;
    if (model_ok) begin
      check("model_out", out, exp_out);
      check("model_full", {27'd0, full}, {27'd0, exp_full});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_shift = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic load(input logic [15:0] d);
    in_valid = 1'b1;
    in_shift = 1'b0;
    in_data  = d;
    tick();
    idle();
  endtask

  task automatic shift(input logic [3:0] n);
    in_valid = 1'b1;
    in_shift = 1'b1;
    in_data  = {12'hFFF, n};
    tick();
    idle();
  endtask

  localparam logic [27:0] V1234 = {7'h79, 7'h24, 7'h30, 7'h19};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_shift = 1'b0; in_data = '0;
    clear = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
    tick();
    check("reset_out", out, BLANK4);
    check("reset_full", {27'd0, full}, 28'd0);
    rst = 1'b0;
    tick();
    check("post_reset_zero", out, ZERO4);

    // word load, no blanking
    load(16'h1D0F);
    check("load_full_same_edge", {27'd0, full}, 28'd1);
    tick();
    check("load_1D0F", out, {7'h79, 7'h21, 7'h40, 7'h0E});

    // leading-zero blanking and its one-edge response
    blank_lz = 1'b1;
    load(16'h0042);
    tick();
    check("lz_0042", out, {7'h7F, 7'h7F, 7'h19, 7'h24});
    blank_lz = 1'b0;
    tick();
    check("lz_off_0042", out, {7'h40, 7'h40, 7'h19, 7'h24});
    blank_lz = 1'b1;
    load(16'h0100);
    tick();
    check("lz_0100", out, {7'h7F, 7'h79, 7'h40, 7'h40});
    load(16'h0000);
    tick();
    check("lz_zero_keeps_digit0", out, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    blank_lz = 1'b0;

    // clear then nibble shifts, including one past full
    clear = 1'b1;
    tick();
    idle();
    check("clear_full", {27'd0, full}, 28'd0);
    shift(4'hA); check("shift_A_full", {27'd0, full}, 28'd0);
    shift(4'hB); check("shift_B_full", {27'd0, full}, 28'd0);
    shift(4'hC); check("shift_C_full", {27'd0, full}, 28'd0);
    shift(4'hD); check("shift_D_full", {27'd0, full}, 28'd1);
    shift(4'hE); check("shift_E_full", {27'd0, full}, 28'd1);
    tick();
    check("shift_BCDE", out, {7'h03, 7'h46, 7'h21, 7'h06});

    // clear wins over a simultaneous load
    clear = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
    tick();
    idle();
    check("clear_over_load_full", {27'd0, full}, 28'd0);
    tick();
    check("clear_over_load_out", out, ZERO4);
    shift(4'h7);
    check("count_restart_full", {27'd0, full}, 28'd0);

    // blink: 4 visible, 4 blank, 4 visible, then disable mid-blank
    load(16'h1234);
    tick();
    check("pre_blink", out, V1234);
    blink_en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      check("blink_cycle", out, (((c / 4) % 2) == 1) ? BLANK4 : V1234);
    end
    blink_en = 1'b0;
    tick();
    check("blink_off_visible", out, V1234);

    // reset while blanked and full
    blink_en = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    check("pre_rst_blank", out, BLANK4);
    rst = 1'b1;
    tick();
    check("rst_mid_blink_out", out, BLANK4);
    check("rst_mid_blink_full", {27'd0, full}, 28'd0);
    rst = 1'b0;
    tick();
    check("after_rst_out", out, ZERO4);
    check("after_rst_full", {27'd0, full}, 28'd0);
    blink_en = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hex_display.md
HEX_DISPLAY -- requirements
Module: hex_display

Interface
REQ-001 Parameter DIGITS, default 4, number of hex digits/7-segment displays; legal range 1..8.
REQ-002 Parameter BLINK_CYCLES, default 25_000_000, clock cycles per blink half-period; legal range >= 1.
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = segment lit when its bit is 0, 0 = lit when 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  load/shift strobe, sampled each rising edge.
REQ-007 in_shift  input  1  qualifies in_valid: 0 = full-word load, 1 = single-nibble shift-in.
REQ-008 in_data  input  4*DIGITS  load word; in_data[3:0] is the shift nibble.
REQ-009 clear  input  1  synchronous clear of the held value and nibble count.
REQ-010 blank_lz  input  1  leading-zero blanking enable, level.
REQ-011 blink_en  input  1  blink enable, level.
REQ-012 out  output  7*DIGITS  registered segments; digit i on out[7i+6:7i], bit order gfedcba.
REQ-013 full  output  1  registered; high when nibble count equals DIGITS.

Function
REQ-014 Held value V (4*DIGITS bits); nibble V[4i+3:4i] drives digit i.
REQ-015 Priority per edge: rst > clear > in_valid; clear sets V=0 and count=0, ignoring in_valid.
REQ-016 in_valid=1, in_shift=0: V <= in_data; count <= DIGITS.
REQ-017 in_valid=1, in_shift=1: V <= {V[4*DIGITS-5:0], in_data[3:0]}, MS nibble discarded; count <= min(count+1, DIGITS).
REQ-018 DIGITS=1 shift: V <= in_data[3:0].
REQ-019 Shift while full: V still shifts; count stays DIGITS; full stays 1.
REQ-020 Decode, active-high form: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71; ACTIVE_LOW=1 inverts each 7-bit field.
REQ-021 Blank digit = all segments off (7'h7F with ACTIVE_LOW=1, 7'h00 otherwise).
REQ-022 blank_lz=1: every digit above the most significant nonzero nibble is blanked; digit 0 is never lz-blanked (V=0 shows single "0").
REQ-023 Blink counter 0..BLINK_CYCLES-1 and phase bit; while blink_en=1, counter increments each cycle, wraps to 0 at BLINK_CYCLES-1 and toggles phase on wrap.
REQ-024 blink_en=0: counter and phase held at 0 on the next edge; re-enable starts with a full visible half-period.
REQ-025 phase=1: all digits blanked, overriding decode and lz; V, count and full unaffected.
REQ-026 out is registered from current V, blank_lz, blink state: V change at edge k appears on out at edge k+1; blank_lz/blink_en/phase change at edge k appears at edge k+1.
REQ-027 full is registered from count, updating on the same edge as count.
REQ-028 No combinational path from any input to out or full.

Reset
REQ-029 rst=1 at an edge: V=0, count=0, full=0, counter=0, phase=0, out=all digits blank.
REQ-030 First edge after rst deasserts: out reflects V=0 under current blank_lz/blink_en.
REQ-031 rst mid-blink or mid-shift aborts immediately; no residual blink phase or partial count.

Verification (DIGITS=4, ACTIVE_LOW=1, BLINK_CYCLES=4 bench override)
REQ-032 Load in_data=16'h1D0F, blank_lz=0 -> two edges later out[27:21]=7'h79, [20:14]=7'h21, [13:7]=7'h40, [6:0]=7'h0E; full=1.
REQ-033 Load 16'h0042, blank_lz=1 -> out[27:14]=two 7'h7F, [13:7]=7'h19, [6:0]=7'h24; toggle blank_lz=0 -> digits 3,2 become 7'h40 one edge later.
REQ-034 clear, then shift nibbles A,B,C,D,E -> full=0 after A..C, 1 after D; final V=16'hBCDE; out digits 7'h03,7'h46,7'h21,7'h06.
REQ-035 clear and in_valid same cycle with in_data=16'hFFFF -> V=0, count=0, full=0.
REQ-036 V=16'h1234, blink_en=1 -> out visible 4 cycles, all 7'h7F 4 cycles, repeating; blink_en=0 mid-blank -> visible next edge.
REQ-037 rst asserted during blank phase with full=1 -> next edge out all 7'h7F, full=0; after release out shows 7'h40 on every digit (blank_lz=0).
